// File: rtl/micro_sequencer_if.sv
// Sequencer <-> control-unit bundle: sequencing fields of the current
// microinstruction in, control-store address and status out.
interface micro_sequencer_if #(
  parameter int AW = 5
);
  logic          start;
  logic          stall;
  logic [2:0]    next_sel;
  logic [AW-1:0] branch_addr;
  logic          uhalt;
  logic          z_flag;
  logic [AW-1:0] map_addr;
  logic [AW-1:0] upc;
  logic          run;
  logic          done;
  logic          err;

  // control unit / control store side
  modport master (
    output start, stall, next_sel, branch_addr, uhalt, z_flag, map_addr,
    input  upc, run, done, err
  );

  // sequencer side
  modport slave (
    input  start, stall, next_sel, branch_addr, uhalt, z_flag, map_addr,
    output upc, run, done, err
  );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registered uPC with INC/JUMP/MAP/JZ/JNZ/FETCH
// and a one-deep micro-subroutine (CALL/RET).
// Optional feature macro: MSEQ_CALL_EN. When undefined there is no return
// register, CALL acts as JUMP, RET acts as FETCH and err stays 0.
module micro_sequencer #(
  parameter int            AW         = 5,
  parameter logic [AW-1:0] FETCH_ADDR = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  micro_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_e;

  localparam logic [2:0] SEL_INC   = 3'd0;
  localparam logic [2:0] SEL_JUMP  = 3'd1;
  localparam logic [2:0] SEL_MAP   = 3'd2;
  localparam logic [2:0] SEL_JZ    = 3'd3;
  localparam logic [2:0] SEL_JNZ   = 3'd4;
  localparam logic [2:0] SEL_FETCH = 3'd5;
  localparam logic [2:0] SEL_CALL  = 3'd6;
  localparam logic [2:0] SEL_RET   = 3'd7;

  state_e        state_q;
  logic [AW-1:0] upc_q, upc_inc, seq_d;
  logic          run_q, done_q, err_q;
`ifdef MSEQ_CALL_EN
  logic [AW-1:0] ret_q;
  logic          ret_vld_q;
`endif

  // Next-address mux; the increment wraps naturally at AW bits.
  always_comb begin
    upc_inc = upc_q + 1'b1;
    seq_d   = upc_inc;
    unique case (bus.next_sel)
      SEL_INC:   seq_d = upc_inc;
      SEL_JUMP:  seq_d = bus.branch_addr;
      SEL_MAP:   seq_d = bus.map_addr;
      SEL_JZ:    seq_d = bus.z_flag  ? bus.branch_addr : upc_inc;
      SEL_JNZ:   seq_d = !bus.z_flag ? bus.branch_addr : upc_inc;
      SEL_FETCH: seq_d = FETCH_ADDR;
      SEL_CALL:  seq_d = bus.branch_addr;
`ifdef MSEQ_CALL_EN
      SEL_RET:   seq_d = ret_vld_q ? ret_q : FETCH_ADDR;
`else
      SEL_RET:   seq_d = FETCH_ADDR;
`endif
      default:   seq_d = upc_inc;
    endcase
  end

  // Control FSM with registered uPC, status outputs and return register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      upc_q     <= FETCH_ADDR;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef MSEQ_CALL_EN
      ret_q     <= '0;
      ret_vld_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE, S_HALTED: begin
          if (bus.start) begin
            state_q   <= S_RUN;
            upc_q     <= FETCH_ADDR;
            run_q     <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef MSEQ_CALL_EN
            ret_vld_q <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          // stall freezes everything, including a pending halt or CALL/RET
          if (!bus.stall) begin
            if (bus.uhalt) begin
              state_q <= S_HALTED;
              run_q   <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              upc_q <= seq_d;
`ifdef MSEQ_CALL_EN
              if (bus.next_sel == SEL_CALL) begin
                ret_q     <= upc_inc;
                ret_vld_q <= 1'b1;
              end else if (bus.next_sel == SEL_RET) begin
                if (ret_vld_q) ret_vld_q <= 1'b0;
                else           err_q     <= 1'b1;
              end
`endif
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          run_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.upc  = upc_q;
  assign bus.run  = run_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed test-plan scenarios followed by a
// randomized run compared against a behavioural model (AW=5, FETCH_ADDR=0).
module tb_micro_sequencer;
  localparam int AW = 5;
  localparam int MODN = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  micro_sequencer_if #(.AW(AW)) bus();
  micro_sequencer #(.AW(AW), .FETCH_ADDR(5'd0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  // model state: 0 idle, 1 run, 2 halted
  int m_st, m_upc, m_ret;
  bit m_rv, m_err;

  function automatic logic [7:0] obs();
    return {bus.upc, bus.run, bus.done, bus.err};
  endfunction

  function automatic logic [7:0] mexp();
    return {5'(m_upc), m_st == 1, m_st == 2, m_err};
  endfunction

  task automatic model_reset();
    m_st = 0; m_upc = 0; m_ret = 0; m_rv = 0; m_err = 0;
  endtask

  // Behavioural next-state computed from the sequencing rules.
  task automatic model_step();
    int inc;
    inc = (m_upc + 1) % MODN;
    if (m_st != 1) begin
      if (bus.start) begin m_st = 1; m_upc = 0; m_err = 0; m_rv = 0; end
    end else if (!bus.stall) begin
      if (bus.uhalt) m_st = 2;
      else case (int'(bus.next_sel))
        0: m_upc = inc;
        1: m_upc = int'(bus.branch_addr);
        2: m_upc = int'(bus.map_addr);
        3: m_upc = bus.z_flag ? int'(bus.branch_addr) : inc;
        4: m_upc = !bus.z_flag ? int'(bus.branch_addr) : inc;
        5: m_upc = 0;
`ifdef MSEQ_CALL_EN
        6: begin m_ret = inc; m_rv = 1; m_upc = int'(bus.branch_addr); end
        7: if (m_rv) begin m_upc = m_ret; m_rv = 0; end
           else begin m_upc = 0; m_err = 1; end
`else
        6: m_upc = int'(bus.branch_addr);
        7: m_upc = 0;
`endif
        default: m_upc = inc;
      endcase
    end
  endtask

  task automatic drive(bit st, bit stl, int sel, int ba, bit uh, bit z, int ma);
    bus.start = st; bus.stall = stl; bus.next_sel = 3'(sel);
    bus.branch_addr = 5'(ba); bus.uhalt = uh; bus.z_flag = z; bus.map_addr = 5'(ma);
  endtask

  // One clock: model follows the same sampled inputs, outputs read 1ns later.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    checks++; if (obs() !== 8'h00) begin failures++; $display("FAIL reset_init got=%h want=%h", obs(), 8'h00); end
    @(negedge clk); rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    checks++; if (obs() !== {5'd0, 3'b100}) begin failures++; $display("FAIL start_run got=%h want=%h", obs(), {5'd0, 3'b100}); end
    drive(0, 0, 1, 9, 0, 0, 0); tick();
    checks++; if (obs() !== {5'd9, 3'b100}) begin failures++; $display("FAIL jump9 got=%h want=%h", obs(), {5'd9, 3'b100}); end
    #2; rst_n = 1'b0; model_reset(); #1;
    checks++; if (obs() !== 8'h00) begin failures++; $display("FAIL async_reset got=%h want=%h", obs(), 8'h00); end
    @(negedge clk); rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    checks++; if (obs() !== {5'd0, 3'b100}) begin failures++; $display("FAIL restart got=%h want=%h", obs(), {5'd0, 3'b100}); end
  endtask

  task automatic test_inc_stall();
    drive(0, 0, 1, 30, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    checks++; if (bus.upc !== 5'd31) begin failures++; $display("FAIL inc_31 got=%0d want=31", bus.upc); end
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.upc !== 5'd31) begin failures++; $display("FAIL stall_hold%0d got=%0d want=31", i, bus.upc); end
    end
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    checks++; if (bus.upc !== 5'd0) begin failures++; $display("FAIL inc_wrap got=%0d want=0", bus.upc); end
  endtask

  task automatic test_branches();
    drive(0, 0, 2, 0, 0, 0, 5'b10011); tick();
    checks++; if (bus.upc !== 5'd19) begin failures++; $display("FAIL map got=%0d want=19", bus.upc); end
    drive(0, 0, 3, 10, 0, 1, 0); tick();
    checks++; if (bus.upc !== 5'd10) begin failures++; $display("FAIL jz_taken got=%0d want=10", bus.upc); end
    drive(0, 0, 1, 12, 0, 0, 0); tick();
    drive(0, 0, 4, 3, 0, 1, 0); tick();
    checks++; if (bus.upc !== 5'd13) begin failures++; $display("FAIL jnz_not_taken got=%0d want=13", bus.upc); end
  endtask

  task automatic test_call_ret();
    logic [7:0] want;
    drive(0, 0, 1, 4, 0, 0, 0); tick();
    drive(0, 0, 6, 24, 0, 0, 0); tick();
    checks++; if (bus.upc !== 5'd24) begin failures++; $display("FAIL call got=%0d want=24", bus.upc); end
    drive(0, 0, 7, 17, 0, 0, 0); tick();
`ifdef MSEQ_CALL_EN
    want = {5'd5, 3'b100};
`else
    want = {5'd0, 3'b100};
`endif
    checks++; if (obs() !== want) begin failures++; $display("FAIL ret1 got=%h want=%h", obs(), want); end
    tick();
`ifdef MSEQ_CALL_EN
    want = {5'd0, 3'b101};
`else
    want = {5'd0, 3'b100};
`endif
    checks++; if (obs() !== want) begin failures++; $display("FAIL ret2 got=%h want=%h", obs(), want); end
  endtask

  task automatic test_halt();
    logic errb;
`ifdef MSEQ_CALL_EN
    errb = 1'b1;
`else
    errb = 1'b0;
`endif
    drive(0, 0, 1, 28, 0, 0, 0); tick();
    drive(0, 1, 1, 3, 1, 0, 0); tick();
    checks++; if (obs() !== {5'd28, 2'b10, errb}) begin failures++; $display("FAIL halt_stalled got=%h want=%h", obs(), {5'd28, 2'b10, errb}); end
    drive(0, 0, 1, 3, 1, 0, 0); tick();
    checks++; if (obs() !== {5'd28, 2'b01, errb}) begin failures++; $display("FAIL halted got=%h want=%h", obs(), {5'd28, 2'b01, errb}); end
    drive(0, 0, 0, 0, 0, 0, 0); tick(); tick();
    checks++; if (obs() !== {5'd28, 2'b01, errb}) begin failures++; $display("FAIL halted_hold got=%h want=%h", obs(), {5'd28, 2'b01, errb}); end
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    checks++; if (obs() !== {5'd0, 3'b100}) begin failures++; $display("FAIL halt_restart got=%h want=%h", obs(), {5'd0, 3'b100}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2; rst_n = 1'b0; model_reset(); #1;
        checks++; if (obs() !== mexp()) begin failures++; $display("FAIL rand_reset%0d got=%h want=%h", i, obs(), mexp()); end
        @(negedge clk); rst_n = 1'b1;
      end
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0, int'($urandom_range(0, 7)),
            int'($urandom_range(0, MODN - 1)), $urandom_range(0, 24) == 0, 1'($urandom),
            int'($urandom_range(0, MODN - 1)));
      tick();
      checks++; if (obs() !== mexp()) begin failures++; $display("FAIL rand%0d got=%h want=%h", i, obs(), mexp()); end
    end
  endtask

  initial begin
    test_reset();
    test_inc_stall();
    test_branches();
    test_call_ret();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer for the core control unit. Holds the micro-program counter (uPC) that addresses the control store, and selects each cycle's next address from increment, branch, Z-flag conditional branch, the opcode-mapped entry address, return to fetch, or a one-deep micro-subroutine. The opcode mapper supplies `map_addr`; the control store decodes `upc` and returns the sequencing fields of the current microinstruction.

## Interface
- `AW`, 5, control-store address width
- `FETCH_ADDR`, 0, uPC of the first fetch microinstruction; reset and restart target
- `clk`  in  1  clock; all state changes on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; leaves IDLE or HALTED and begins execution at `FETCH_ADDR`
- `stall`  in  1  holds uPC and all state for the cycle (memory/bus wait)
- `next_sel`  in  3  sequencing field of the current microinstruction
- `branch_addr`  in  AW  branch/call target field of the current microinstruction
- `uhalt`  in  1  halt bit of the current microinstruction
- `z_flag`  in  1  ALU zero flag, sampled at posedge
- `map_addr`  in  AW  entry address from the opcode mapper; stable before posedge
- `upc`  out  AW  control-store address
- `run`  out  1  high in RUN state
- `done`  out  1  high in HALTED state
- `err`  out  1  sticky: RET executed with no saved return address

## Operation
- States: IDLE, RUN, HALTED. Reset -> IDLE, `upc`=`FETCH_ADDR`, `run`=0, `done`=0, `err`=0, return register cleared and invalid.
- IDLE/HALTED + `start` -> RUN, `upc`=`FETCH_ADDR`, `err` cleared, return register invalidated. `start` in RUN is ignored.
- In RUN with `stall`=0, `next_sel` selects the next uPC:
  - 0 INC: `upc`+1, modulo 2^AW (all-ones wraps to 0)
  - 1 JUMP: `branch_addr`
  - 2 MAP: `map_addr`
  - 3 JZ: `z_flag` ? `branch_addr` : `upc`+1
  - 4 JNZ: !`z_flag` ? `branch_addr` : `upc`+1
  - 5 FETCH: `FETCH_ADDR`
  - 6 CALL: return register <= `upc`+1 (valid), `upc` <= `branch_addr`
  - 7 RET: if valid, `upc` <= return register, valid cleared; else `upc` <= `FETCH_ADDR`, `err` <= 1
- `uhalt`=1 in RUN with `stall`=0: -> HALTED, `upc` held at the halting address, `next_sel` ignored.
- `stall`=1 overrides everything in RUN, including `uhalt` and CALL/RET; the same microinstruction is re-evaluated next cycle.
- A second CALL while the return register is valid overwrites it (depth one).
- `rst_n` low at any time, including mid-CALL or stall, forces the reset values immediately.

## Timing
- `upc` is registered. The next address is visible one cycle after the posedge that samples `next_sel`/`branch_addr`/`z_flag`/`map_addr`.
- Control-store fields are combinational from `upc` and valid in the same cycle.
- MAP dispatch: `map_addr` must be valid at the posedge on which `next_sel`=2. The opcode mapper registers IR on posedge and drives `map_addr` from negedge, so IR must have been loaded at least one posedge earlier.
- `run`/`done` change with the state register; `start`->`run`=1 takes one cycle.

## Configuration
- `MSEQ_CALL_EN` defined: CALL/RET and the return register behave as described.
- Not defined: no return register. CALL (6) behaves as JUMP. RET (7) behaves as FETCH. `err` is tied to 0.

## Test plan
- Reset with `rst_n`=0 mid-RUN at `upc`=9 -> `upc`=0, `run`=0, `done`=0, `err`=0 immediately. `start` -> `upc`=0, `run`=1 next cycle.
- INC chain from `upc`=30 (AW=5) -> 31, then 0. `stall`=1 at 31 for 3 cycles -> `upc` stays 31.
- MAP with `map_addr`=5'b10011 -> `upc`=19. JZ with `branch_addr`=10, `z_flag`=1 -> 10. JNZ with `z_flag`=1 at `upc`=12 -> 13.
- CALL at `upc`=4 with `branch_addr`=24, then RET -> 24, then 5. A second RET -> `upc`=0, `err`=1 (without macro: CALL->24, RET->0, `err`=0).
- `uhalt`=1 at `upc`=28 -> HALTED, `done`=1, `upc`=28 held. `uhalt` with `stall`=1 -> remains RUN. `start` -> `upc`=0, `done`=0, `err`=0.
